// File: rtl/commit_queue_if.sv
// rtl/commit_queue_if.sv - retired-instruction stream and status bundle for commit_queue
interface commit_queue_if #(
  parameter int CNT_WIDTH = 64
);
  logic                 commitValidI;
  logic [63:0]          pcI;
  logic [31:0]          instI;
  logic                 rdWriteEnableI;
  logic [4:0]           rdWriteAddrI;
  logic [63:0]          rdWriteDataI;

  logic                 commitValidO;
  logic                 commitReadyI;
  logic [63:0]          pcO;
  logic [31:0]          instO;
  logic                 rdWriteEnableO;
  logic [4:0]           rdWriteAddrO;
  logic [63:0]          rdWriteDataO;

  logic                 queueFullO;
  logic                 queueEmptyO;
  logic                 overflowO;
  logic [CNT_WIDTH-1:0] instrCntO;
  logic [CNT_WIDTH-1:0] cycleCntO;

  modport slave (
    input  commitValidI, pcI, instI, rdWriteEnableI, rdWriteAddrI, rdWriteDataI,
    input  commitReadyI,
    output commitValidO, pcO, instO, rdWriteEnableO, rdWriteAddrO, rdWriteDataO,
    output queueFullO, queueEmptyO, overflowO, instrCntO, cycleCntO
  );

  modport master (
    output commitValidI, pcI, instI, rdWriteEnableI, rdWriteAddrI, rdWriteDataI,
    output commitReadyI,
    input  commitValidO, pcO, instO, rdWriteEnableO, rdWriteAddrO, rdWriteDataO,
    input  queueFullO, queueEmptyO, overflowO, instrCntO, cycleCntO
  );
endinterface

// File: rtl/commit_queue.sv
// rtl/commit_queue.sv - show-ahead FIFO from wb_stage to the difftest checker, with trap counters
module commit_queue #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic          clk,
  input  logic          rst,
  commit_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               wr_entry;
  entry_t               head;

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;

  logic full, empty, push, pop, drop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.commitReadyI;
  // a full queue still accepts a commit when the head leaves in the same cycle
  assign push  = bus.commitValidI && (!full || pop);
  assign drop  = bus.commitValidI && full && !pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.pc   = bus.pcI;
    wr_entry.inst = bus.instI;
    wr_entry.en   = bus.rdWriteEnableI && (bus.rdWriteAddrI != 5'd0);
    wr_entry.addr = bus.rdWriteAddrI;
    wr_entry.data = bus.rdWriteDataI;
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (pop && !push) count_d = count_q - CNT_W'(1);
    overflow_d  = overflow_q || drop;
    instr_cnt_d = pop ? instr_cnt_q + CNT_WIDTH'(1) : instr_cnt_q;
    cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
  end

  // storage is deliberately left out of reset; valid tracking lives in count_q
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      instr_cnt_q <= '0;
      cycle_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      instr_cnt_q <= instr_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign head = mem_q[rd_ptr_q];

  // head fields are masked so the checker never sees stale or X data
  assign bus.commitValidO   = !empty;
  assign bus.pcO            = empty ? 64'd0 : head.pc;
  assign bus.instO          = empty ? 32'd0 : head.inst;
  assign bus.rdWriteEnableO = empty ? 1'b0  : head.en;
  assign bus.rdWriteAddrO   = empty ? 5'd0  : head.addr;
  assign bus.rdWriteDataO   = empty ? 64'd0 : head.data;

  assign bus.queueFullO  = full;
  assign bus.queueEmptyO = empty;
  assign bus.overflowO   = overflow_q;
  assign bus.instrCntO   = instr_cnt_q;
  assign bus.cycleCntO   = cycle_cnt_q;

endmodule

// File: tb/tb_commit_queue.sv
// tb/tb_commit_queue.sv - bench for commit_queue
module tb_commit_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } ent_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  commit_queue_if #(.CNT_WIDTH(64)) bus();
  commit_queue #(.DEPTH(DEPTH), .CNT_WIDTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        sb[$];
  logic [63:0] popped_pc[$];
  bit          m_known  = 1'b0;
  bit          m_ovf    = 1'b0;
  logic [63:0] m_instr  = 64'd0;
  logic [63:0] m_cycle  = 64'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] inst,
                       input logic en, input logic [4:0] addr, input logic [63:0] data,
                       input logic rdy);
    bus.commitValidI   = v;
    bus.pcI            = pc;
    bus.instI          = inst;
    bus.rdWriteEnableI = en;
    bus.rdWriteAddrI   = addr;
    bus.rdWriteDataI   = data;
    bus.commitReadyI   = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 64'd0, 32'd0, 1'b0, 5'd0, 64'd0, rdy);
  endtask

  // compare DUT against the scoreboard mid-cycle, then advance the model across the edge
  task automatic cycle();
    bit   pop, push;
    ent_t e;
    @(negedge clk);
    if (m_known) begin
      check("valid", {63'd0, bus.commitValidO}, {63'd0, sb.size() != 0});
      check("empty", {63'd0, bus.queueEmptyO}, {63'd0, sb.size() == 0});
      check("full", {63'd0, bus.queueFullO}, {63'd0, sb.size() == DEPTH});
      check("overflow", {63'd0, bus.overflowO}, {63'd0, m_ovf});
      check("instr_cnt", bus.instrCntO, m_instr);
      check("cycle_cnt", bus.cycleCntO, m_cycle);
      if (sb.size() != 0) begin
        check("head_inst", {32'd0, bus.instO}, {32'd0, sb[0].inst});
        check("head_en", {63'd0, bus.rdWriteEnableO}, {63'd0, sb[0].en});
        check("head_addr", {59'd0, bus.rdWriteAddrO}, {59'd0, sb[0].addr});
        check("head_data", bus.rdWriteDataO, sb[0].data);
      end else begin
        check("mask_pc", bus.pcO, 64'd0);
        check("mask_fields", {27'd0, bus.instO, bus.rdWriteEnableO, bus.rdWriteAddrO},
              64'd0);
        check("mask_data", bus.rdWriteDataO, 64'd0);
      end
    end
    if (rst) begin
      sb.delete();
      m_ovf   = 1'b0;
      m_instr = 64'd0;
      m_cycle = 64'd0;
      m_known = 1'b1;
    end else if (m_known) begin
      pop  = (sb.size() != 0) && bus.commitReadyI;
      push = bus.commitValidI && ((sb.size() < DEPTH) || pop);
      if (bus.commitValidI && !push) m_ovf = 1'b1;
      if (pop) begin
        check("pop_pc", bus.pcO, sb[0].pc);
        popped_pc.push_back(bus.pcO);
        void'(sb.pop_front());
        m_instr++;
      end
      if (push) begin
        e.pc   = bus.pcI;
        e.inst = bus.instI;
        e.en   = bus.rdWriteEnableI && (bus.rdWriteAddrI != 5'd0);
        e.addr = bus.rdWriteAddrI;
        e.data = bus.rdWriteDataI;
        sb.push_back(e);
      end
      m_cycle++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(1'b0);
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget);
    idle(1'b1);
    for (int i = 0; i < budget && !bus.queueEmptyO; i++) cycle();
    check("drain_done", {63'd0, bus.queueEmptyO}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   k;
    vecs[0] = '{1'b1, 5'd1,  64'd1,          1'b1, 5'd1,  64'd1};
    vecs[1] = '{1'b1, 5'd0,  64'd5,          1'b0, 5'd0,  64'd5};
    vecs[2] = '{1'b0, 5'd7,  64'hAA,         1'b0, 5'd7,  64'hAA};
    vecs[3] = '{1'b1, 5'd31, 64'hDEADBEEF00, 1'b1, 5'd31, 64'hDEADBEEF00};
    vecs[4] = '{1'b0, 5'd0,  64'h0,          1'b0, 5'd0,  64'h0};
    vecs[5] = '{1'b1, 5'd2,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF};

    idle(1'b0);
    cycle();
    do_reset();
    check("rst_valid", {63'd0, bus.commitValidO}, 64'd0);
    check("rst_empty", {63'd0, bus.queueEmptyO}, 64'd1);
    check("rst_full", {63'd0, bus.queueFullO}, 64'd0);
    check("rst_ovf", {63'd0, bus.overflowO}, 64'd0);
    check("rst_instr", bus.instrCntO, 64'd0);
    check("rst_cycle", bus.cycleCntO, 64'd0);

    drive(1'b1, 64'h8000_0000, 32'h0010_0093, 1'b1, 5'd1, 64'd1, 1'b1);
    cycle();
    idle(1'b1);
    check("t1_valid", {63'd0, bus.commitValidO}, 64'd1);
    check("t1_pc", bus.pcO, 64'h8000_0000);
    check("t1_inst", {32'd0, bus.instO}, 64'h0010_0093);
    check("t1_rd", {58'd0, bus.rdWriteEnableO, bus.rdWriteAddrO}, 64'h21);
    check("t1_data", bus.rdWriteDataO, 64'd1);
    check("t1_instr0", bus.instrCntO, 64'd0);
    cycle();
    check("t1_instr1", bus.instrCntO, 64'd1);
    check("t1_empty", {63'd0, bus.queueEmptyO}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'h100 + 64'(i), 32'h13, vecs[i].en, vecs[i].addr, vecs[i].data, 1'b0);
      cycle();
      idle(1'b0);
      check("vec_en", {63'd0, bus.rdWriteEnableO}, {63'd0, vecs[i].exp_en});
      check("vec_addr", {59'd0, bus.rdWriteAddrO}, {59'd0, vecs[i].exp_addr});
      check("vec_data", bus.rdWriteDataO, vecs[i].exp_data);
      drain(4);
    end

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'h13, 1'b1, 5'd3, 64'(i), 1'b0);
      cycle();
    end
    check("full_flag", {63'd0, bus.queueFullO}, 64'd1);
    check("full_head", bus.pcO, 64'h1000);
    check("full_noovf", {63'd0, bus.overflowO}, 64'd0);
    drive(1'b1, 64'h1010, 32'h13, 1'b1, 5'd3, 64'd9, 1'b0);
    cycle();
    idle(1'b0);
    check("ovf_set", {63'd0, bus.overflowO}, 64'd1);
    check("ovf_full", {63'd0, bus.queueFullO}, 64'd1);
    check("ovf_head", bus.pcO, 64'h1000);
    cycle();
    check("ovf_sticky", {63'd0, bus.overflowO}, 64'd1);

    do_reset();
    check("ovf_cleared", {63'd0, bus.overflowO}, 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'h13, 1'b1, 5'd4, 64'(i), 1'b0);
      cycle();
    end
    drive(1'b1, 64'h2000, 32'h13, 1'b1, 5'd4, 64'd7, 1'b1);
    cycle();
    idle(1'b0);
    check("pp_full", {63'd0, bus.queueFullO}, 64'd1);
    check("pp_head", bus.pcO, 64'h1004);
    check("pp_noovf", {63'd0, bus.overflowO}, 64'd0);
    drain(8);

    do_reset();
    popped_pc.delete();
    k = 0;
    for (int c = 0; c < 60 && (k < 10 || !bus.queueEmptyO); c++) begin
      if (k < 10 && (c % 2 == 0)) begin
        drive(1'b1, 64'h3000 + 64'(4 * k), 32'h13, 1'b1, 5'd5, 64'(k), c[0]);
        k++;
      end else begin
        idle(c[0]);
      end
      cycle();
    end
    check("stream_count", 64'(popped_pc.size()), 64'd10);
    for (int i = 0; i < popped_pc.size(); i++)
      check("stream_order", popped_pc[i], 64'h3000 + 64'(4 * i));
    check("stream_instr", bus.instrCntO, 64'd10);
    check("stream_noovf", {63'd0, bus.overflowO}, 64'd0);

    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h4000 + 64'(4 * i), 32'h13, 1'b1, 5'd6, 64'(i), 1'b0);
      cycle();
    end
    rst = 1'b1;
    drive(1'b1, 64'h5000, 32'h13, 1'b1, 5'd6, 64'd8, 1'b1);
    cycle();
    rst = 1'b0;
    idle(1'b0);
    check("mid_valid", {63'd0, bus.commitValidO}, 64'd0);
    check("mid_empty", {63'd0, bus.queueEmptyO}, 64'd1);
    check("mid_instr", bus.instrCntO, 64'd0);
    check("mid_cycle", bus.cycleCntO, 64'd0);
    cycle();
    check("mid_cycle1", bus.cycleCntO, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
